axi_read_intf: RTL and testbench
================================

# axi_read_intf

AXI4 read-channel slave for the TPU target: accepts read bursts addressed to the TPU on the AR channel, walks the burst address sequence, and issues one request per beat to the internal storage. Each returned word is driven on the R channel with RID/RRESP/RLAST. It is the read-direction companion of the TPU's AXI write slave and shares the same internal-bus style (`axi_rd_*` signals). One burst is outstanding at a time.

## Interface
- `ID_WIDTH`, 8: AXI ID width.
- `ADDR_WIDTH`, 11: byte-address width.
- `DATA_WIDTH`, 32: R data width; `DATA_WIDTH/8` bytes per beat maximum.
- `TPU_ID`, 8'h00: the only ARID this target answers.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ARID` in ID_WIDTH; `ARADDR` in ADDR_WIDTH; `ARLEN` in 8; `ARSIZE` in 3; `ARBURST` in 2: AR payload.
- `ARVALID` in 1; `ARREADY` out 1: AR handshake.
- `RID` out ID_WIDTH; `RDATA` out DATA_WIDTH; `RRESP` out 2; `RLAST` out 1: R payload.
- `RVALID` out 1; `RREADY` in 1: R handshake.
- `axi_rd_doing` out 1: burst in progress.
- `axi_rd_req` out 1: beat read request to storage.
- `axi_rd_addr` out ADDR_WIDTH: beat byte address, valid while `axi_rd_req`.
- `axi_rd_size` out 3: captured ARSIZE.
- `axi_rd_ack` in 1: storage returns data this cycle.
- `axi_rd_data` in DATA_WIDTH: returned word, sampled with `axi_rd_ack`.
- `axi_rd_stat` in 2: beat response code, sampled with `axi_rd_ack`.

## Operation
- FSM: IDLE, REQ, WAIT_R. `ARREADY` = 1 only in IDLE.
- IDLE: AR handshake with `ARID == TPU_ID` captures the AR payload, loads the beat counter with ARLEN, sets `axi_rd_doing`, and moves to REQ. A handshake with any other ARID is discarded with no state change and no response; another target on the shared bus answers it.
- REQ: `axi_rd_req` = 1 with the current address, held until `axi_rd_ack`. On ack, latch `axi_rd_data` into RDATA and `axi_rd_stat` into RRESP, set RVALID and RLAST (RLAST = 1 when the beat counter is 0), and move to WAIT_R.
- WAIT_R: R payload is frozen while `RVALID & ~RREADY`. On the R handshake:
  - last beat: clear RVALID, RLAST and `axi_rd_doing`; go to IDLE.
  - otherwise: decrement the counter, advance the address, clear RVALID; go to REQ.
- Address sequence, step = 1 << ARSIZE, all sums truncated to ADDR_WIDTH:
  - FIXED (00): constant address.
  - INCR (01): address + step.
  - WRAP (10): wrap boundary = (ARLEN+1)·step; the address wraps to the aligned boundary base. Legal ARLEN values are 1, 3, 7 and 15; any other length is treated as INCR.
  - Reserved (11): treated as INCR.
- Oversize: if ARSIZE > log2(DATA_WIDTH/8), all ARLEN+1 beats return RDATA = 0 and RRESP = 2'b10 (SLVERR), and `axi_rd_req` is never asserted. The REQ state completes on its own in one cycle.
- RID = captured ARID.

## Timing
- Reset values (asynchronous, while `rst` = 1): ARREADY 0, RVALID 0, RLAST 0, RDATA 0, RRESP 0, RID 0, `axi_rd_req` 0, `axi_rd_doing` 0, `axi_rd_addr` 0, `axi_rd_size` 0, FSM in IDLE. ARREADY rises at the first rising edge after `rst` falls.
- AR handshake at edge N: `axi_rd_req` is high in cycle N+1.
- Ack in the same cycle as req is legal. Ack at edge M gives RVALID in cycle M+1.
- With zero-wait storage and RREADY held high, throughput is one beat per 2 cycles. An (ARLEN+1)-beat burst takes 2·(ARLEN+1) cycles from AR handshake to the last R handshake.
- ARREADY returns to 1 in the cycle after the last R handshake.
- `axi_rd_ack` outside REQ is ignored.
- `rst` asserted mid-burst aborts immediately: RVALID and `axi_rd_req` drop asynchronously. No partial burst resumes.

## Structure
- Shared package `tpu_axi_pkg` holds:
  - burst encodings FIXED/INCR/WRAP;
  - response encodings OKAY = 2'b00, SLVERR = 2'b10;
  - the `TPU_ID` constant, which is also the parameter default;
  - the FSM state typedef.
- Sub-module `axi_burst_addr_gen` is combinational: inputs current address, size, len and burst; output next address. It is shared with the write slave.
- Registers only in the top module.

## Test plan
- Single beat: ARID = TPU_ID, ARADDR 0x010, ARLEN 0, ARSIZE 2, INCR; storage acks in the req cycle with 0xDEADBEEF/OKAY -> one beat RDATA 0xDEADBEEF, RLAST 1, RRESP 00; ARREADY high again the cycle after the R handshake.
- INCR with backpressure: ARADDR 0x100, ARLEN 3, ARSIZE 2; RREADY low 3 cycles on beat 1 -> req addresses 0x100, 0x104, 0x108, 0x10C; RDATA stable while stalled; RLAST only on beat 3.
- WRAP and FIXED: WRAP ARADDR 0x00C, ARLEN 3, ARSIZE 2 -> addresses 0x00C, 0x000, 0x004, 0x008. FIXED 0x020, ARLEN 2 -> 0x020 three times.
- Foreign ID: ARID ≠ TPU_ID with ARVALID for 1 cycle -> no `axi_rd_req`, no RVALID, `axi_rd_doing` stays 0.
- Oversize and error: ARSIZE 3 with DATA_WIDTH 32, ARLEN 1 -> 2 beats with RRESP 10, RDATA 0, no `axi_rd_req`. A normal beat with `axi_rd_stat` = 10 -> RRESP 10 on that beat only.
- Reset mid-burst: assert `rst` during beat 2 of 4 -> RVALID and `axi_rd_req` fall without waiting for a clock edge. After release, ARREADY = 1 and a new single-beat burst completes normally.

Source files
------------

// File: rtl/tpu_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tpu_axi_pkg
// Brief   : Shared AXI encodings, TPU target ID and read-FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
package tpu_axi_pkg;

  // AXI burst type encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The only AXI ID the TPU target answers
  localparam logic [7:0] TPU_ID = 8'h00;

  // Read slave FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : axi_burst_addr_gen
// Brief   : Combinational next-beat address for FIXED / INCR / WRAP bursts.
//           Shared between the TPU AXI read and write slaves.
// Revision: 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);
  import tpu_axi_pkg::*;

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic                  w_wrap_legal;

  assign w_step = ADDR_WIDTH'(1) << size_i;
  assign w_incr = addr_i + w_step;

  // Window size minus one; modular arithmetic keeps a window equal to the
  // whole address space correct (all-ones mask).
  assign w_wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

  // Only 2/4/8/16-beat wraps are legal; anything else degrades to INCR
  assign w_wrap_legal = (len_i == 8'd1) || (len_i == 8'd3) ||
                        (len_i == 8'd7) || (len_i == 8'd15);

  // Select next address by burst type (reserved encoding behaves as INCR)
  always_comb begin
    next_addr_o = w_incr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP: begin
        if (w_wrap_legal) begin
          next_addr_o = (addr_i & ~w_wrap_mask) | (w_incr & w_wrap_mask);
        end
      end
      default: next_addr_o = w_incr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_intf.sv
`default_nettype none
// ============================================================================
// Module  : axi_read_intf
// Brief   : AXI4 read-channel slave for the TPU target. One burst in flight;
//           each beat is one request to internal storage, returned on R.
// Revision: 1.0 - initial release
// ============================================================================
module axi_read_intf #(
  parameter int                  ID_WIDTH   = 8,
  parameter int                  ADDR_WIDTH = 11,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [ID_WIDTH-1:0] TPU_ID     = ID_WIDTH'(tpu_axi_pkg::TPU_ID)
) (
  input  logic                  clk,
  input  logic                  rst,
  // AR channel
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  // R channel
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  // Internal storage bus
  output logic                  axi_rd_doing,
  output logic                  axi_rd_req,
  output logic [ADDR_WIDTH-1:0] axi_rd_addr,
  output logic [2:0]            axi_rd_size,
  input  logic                  axi_rd_ack,
  input  logic [DATA_WIDTH-1:0] axi_rd_data,
  input  logic [1:0]            axi_rd_stat
);
  import tpu_axi_pkg::*;

  // Largest ARSIZE the data bus can carry in one beat
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

  rd_state_e             state_q,  state_d;
  logic                  arready_q, arready_d;
  logic [ID_WIDTH-1:0]   id_q,     id_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [2:0]            size_q,   size_d;
  logic [1:0]            burst_q,  burst_d;
  logic [7:0]            len_q,    len_d;
  logic [7:0]            cnt_q,    cnt_d;
  logic                  over_q,   over_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic [1:0]            rresp_q,  rresp_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q,  rlast_d;
  logic                  doing_q,  doing_d;

  logic                  w_ar_hs;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_ar_hs = ARVALID & arready_q;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (w_next_addr)
  );

  // Next-state and datapath: capture AR, issue beat requests, hand out R beats
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    size_d   = size_q;
    burst_d  = burst_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    over_d   = over_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    doing_d  = doing_q;

    case (state_q)
      ST_IDLE: begin
        // Foreign IDs belong to another target on the bus: silently ignored
        if (w_ar_hs && (ARID == TPU_ID)) begin
          id_d    = ARID;
          addr_d  = ARADDR;
          size_d  = ARSIZE;
          burst_d = ARBURST;
          len_d   = ARLEN;
          cnt_d   = ARLEN;
          over_d  = (ARSIZE > MAX_SIZE);
          doing_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (over_q) begin
          // Oversize beats never touch storage and answer SLVERR at once
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == 8'd0);
          state_d  = ST_WAIT_R;
        end else if (axi_rd_ack) begin
          rdata_d  = axi_rd_data;
          rresp_d  = axi_rd_stat;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == 8'd0);
          state_d  = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (rvalid_q && RREADY) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            rlast_d = 1'b0;
            doing_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = w_next_addr;
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // ARREADY is registered so it stays low until the first edge after reset
    arready_d = (state_d == ST_IDLE);
  end

  // State and payload registers, cleared asynchronously to abort any burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      over_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      doing_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      over_q    <= over_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      doing_q   <= doing_d;
    end
  end

  assign ARREADY      = arready_q;
  assign RID          = id_q;
  assign RDATA        = rdata_q;
  assign RRESP        = rresp_q;
  assign RLAST        = rlast_q;
  assign RVALID       = rvalid_q;
  assign axi_rd_doing = doing_q;
  assign axi_rd_req   = (state_q == ST_REQ) & ~over_q;
  assign axi_rd_addr  = addr_q;
  assign axi_rd_size  = size_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_intf.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_read_intf
// Brief   : Self-checking bench for axi_read_intf: directed vector table,
//           reset/foreign-ID sequences and randomized bursts against a
//           behavioural address/data model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_read_intf;
  import tpu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID;
  logic [10:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        axi_rd_doing;
  logic        axi_rd_req;
  logic [10:0] axi_rd_addr;
  logic [2:0]  axi_rd_size;
  logic        axi_rd_ack;
  logic [31:0] axi_rd_data;
  logic [1:0]  axi_rd_stat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_read_intf dut (
    .clk          (clk),
    .rst          (rst),
    .ARID         (ARID),
    .ARADDR       (ARADDR),
    .ARLEN        (ARLEN),
    .ARSIZE       (ARSIZE),
    .ARBURST      (ARBURST),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RID          (RID),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RLAST        (RLAST),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .axi_rd_doing (axi_rd_doing),
    .axi_rd_req   (axi_rd_req),
    .axi_rd_addr  (axi_rd_addr),
    .axi_rd_size  (axi_rd_size),
    .axi_rd_ack   (axi_rd_ack),
    .axi_rd_data  (axi_rd_data),
    .axi_rd_stat  (axi_rd_stat)
  );

  typedef struct {
    logic [10:0]      addr;
    int               len;
    int               size;
    logic [1:0]       burst;
    int               err_beat;
    int               stall_beat;
    int               stall_n;
    int               lat;
    bit               use_tab;
    logic [3:0][10:0] exp_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Storage content: a fixed function of the byte address
  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return {5'h15, a, 5'h0A, ~a};
  endfunction

  // Beat address from the burst rules, written as modular arithmetic
  function automatic logic [10:0] model_addr(input logic [10:0] a0, input int len,
                                             input int size, input logic [1:0] burst,
                                             input int i);
    int step, wrapb, base, a;
    step = 1 << size;
    a    = int'(a0);
    if (burst == 2'b00) return a0;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wrapb = (len + 1) * step;
      base  = (a / wrapb) * wrapb;
      return 11'((base + ((a - base) + i * step) % wrapb) % 2048);
    end
    return 11'((a + i * step) % 2048);
  endfunction

  // Run one burst from AR to last R beat; called at a negedge
  task automatic run_burst(input logic [10:0] addr, input int len, input int size,
                           input logic [1:0] burst, input int err_beat,
                           input int stall_beat, input int stall_n, input int lat,
                           input bit use_tab, input logic [3:0][10:0] tab,
                           input int abort_beat);
    int          t, s;
    bit          over;
    logic [10:0] ea;
    logic [31:0] ed;
    logic [1:0]  er;
    over    = (size > 2);
    ARID    = TPU_ID;
    ARADDR  = addr;
    ARLEN   = 8'(len);
    ARSIZE  = 3'(size);
    ARBURST = burst;
    ARVALID = 1'b1;
    t = 0;
    while (ARREADY !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ar_accept", 64'(ARREADY), 64'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    chk("doing_after_ar", 64'(axi_rd_doing), 64'd1);
    chk("arready_busy", 64'(ARREADY), 64'd0);
    for (int b = 0; b <= len; b++) begin
      ea = (use_tab && b < 4) ? tab[b] : model_addr(addr, len, size, burst, b);
      if (over) begin
        ed = 32'h0;
        er = RESP_SLVERR;
        chk("over_no_req", 64'(axi_rd_req), 64'd0);
      end else begin
        ed = mem_word(ea);
        er = (b == err_beat) ? RESP_SLVERR : RESP_OKAY;
        for (int k = 0; k < lat; k++) begin
          chk("req_held", 64'(axi_rd_req), 64'd1);
          chk("rvalid_low_in_req", 64'(RVALID), 64'd0);
          @(negedge clk);
        end
        chk("req", 64'(axi_rd_req), 64'd1);
        chk("req_addr", 64'(axi_rd_addr), 64'(ea));
        chk("req_size", 64'(axi_rd_size), 64'(size));
        axi_rd_ack  = 1'b1;
        axi_rd_data = mem_word(axi_rd_addr);
        axi_rd_stat = er;
      end
      @(negedge clk);
      axi_rd_ack  = 1'b0;
      axi_rd_data = $urandom;
      axi_rd_stat = 2'($urandom);
      chk("rvalid", 64'(RVALID), 64'd1);
      chk("rdata", 64'(RDATA), 64'(ed));
      chk("rresp", 64'(RRESP), 64'(er));
      chk("rlast", 64'(RLAST), 64'(b == len));
      chk("rid", 64'(RID), 64'(TPU_ID));
      chk("no_req_in_wait", 64'(axi_rd_req), 64'd0);
      if (b == abort_beat) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rvalid", 64'(RVALID), 64'd0);
        chk("rst_async_req", 64'(axi_rd_req), 64'd0);
        chk("rst_async_doing", 64'(axi_rd_doing), 64'd0);
        @(negedge clk);
        chk("rst_hold_arready", 64'(ARREADY), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_arready", 64'(ARREADY), 64'd1);
        chk("rst_release_rvalid", 64'(RVALID), 64'd0);
        chk("rst_release_req", 64'(axi_rd_req), 64'd0);
        return;
      end
      if (stall_beat == b)       s = stall_n;
      else if (stall_beat == -2) s = int'($urandom_range(0, 2));
      else                       s = 0;
      // Stalls also wiggle ack, which must be ignored outside REQ
      for (int k = 0; k < s; k++) begin
        RREADY      = 1'b0;
        axi_rd_ack  = 1'b1;
        axi_rd_data = $urandom;
        @(negedge clk);
        chk("stall_rvalid", 64'(RVALID), 64'd1);
        chk("stall_rdata", 64'(RDATA), 64'(ed));
        chk("stall_rlast", 64'(RLAST), 64'(b == len));
      end
      axi_rd_ack = 1'b0;
      RREADY     = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
    end
    chk("arready_after", 64'(ARREADY), 64'd1);
    chk("rvalid_after", 64'(RVALID), 64'd0);
    chk("doing_after", 64'(axi_rd_doing), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len, size, errb, pick;
    logic [1:0]  burst;
    logic [10:0] addr;

    vecs[0] = '{addr:11'h010, len:0, size:2, burst:2'b01, err_beat:-1, stall_beat:-1, stall_n:0,
                lat:0, use_tab:1'b1, exp_addr:{11'h0, 11'h0, 11'h0, 11'h010}};
    vecs[1] = '{addr:11'h100, len:3, size:2, burst:2'b01, err_beat:-1, stall_beat:1, stall_n:3,
                lat:0, use_tab:1'b1, exp_addr:{11'h10C, 11'h108, 11'h104, 11'h100}};
    vecs[2] = '{addr:11'h00C, len:3, size:2, burst:2'b10, err_beat:-1, stall_beat:-1, stall_n:0,
                lat:0, use_tab:1'b1, exp_addr:{11'h008, 11'h004, 11'h000, 11'h00C}};
    vecs[3] = '{addr:11'h020, len:2, size:2, burst:2'b00, err_beat:-1, stall_beat:-1, stall_n:0,
                lat:1, use_tab:1'b1, exp_addr:{11'h0, 11'h020, 11'h020, 11'h020}};
    vecs[4] = '{addr:11'h040, len:1, size:3, burst:2'b01, err_beat:-1, stall_beat:0, stall_n:1,
                lat:0, use_tab:1'b0, exp_addr:{11'h0, 11'h0, 11'h0, 11'h0}};
    vecs[5] = '{addr:11'h040, len:2, size:2, burst:2'b01, err_beat:1, stall_beat:-1, stall_n:0,
                lat:0, use_tab:1'b1, exp_addr:{11'h0, 11'h048, 11'h044, 11'h040}};
    vecs[6] = '{addr:11'h200, len:1, size:1, burst:2'b01, err_beat:-1, stall_beat:-1, stall_n:0,
                lat:2, use_tab:1'b1, exp_addr:{11'h0, 11'h0, 11'h202, 11'h200}};
    vecs[7] = '{addr:11'h00C, len:2, size:2, burst:2'b10, err_beat:-1, stall_beat:-1, stall_n:0,
                lat:0, use_tab:1'b1, exp_addr:{11'h0, 11'h014, 11'h010, 11'h00C}};
    vecs[8] = '{addr:11'h7FF, len:1, size:0, burst:2'b11, err_beat:-1, stall_beat:-1, stall_n:0,
                lat:0, use_tab:1'b1, exp_addr:{11'h0, 11'h0, 11'h000, 11'h7FF}};
    vecs[9] = '{addr:11'h01C, len:1, size:2, burst:2'b10, err_beat:-1, stall_beat:-1, stall_n:0,
                lat:0, use_tab:1'b1, exp_addr:{11'h0, 11'h0, 11'h018, 11'h01C}};

    rst = 1'b1;
    ARID = 8'h0; ARADDR = 11'h0; ARLEN = 8'h0; ARSIZE = 3'h0; ARBURST = 2'b00; ARVALID = 1'b0;
    RREADY = 1'b0; axi_rd_ack = 1'b0; axi_rd_data = 32'h0; axi_rd_stat = 2'b00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_rresp", 64'(RRESP), 64'd0);
    chk("rst_rid", 64'(RID), 64'd0);
    chk("rst_req", 64'(axi_rd_req), 64'd0);
    chk("rst_doing", 64'(axi_rd_doing), 64'd0);
    chk("rst_addr", 64'(axi_rd_addr), 64'd0);
    chk("rst_size", 64'(axi_rd_size), 64'd0);
    rst = 1'b0;
    #1 chk("arready_before_edge", 64'(ARREADY), 64'd0);
    @(negedge clk);
    chk("arready_first_edge", 64'(ARREADY), 64'd1);

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      run_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].err_beat,
                vecs[v].stall_beat, vecs[v].stall_n, vecs[v].lat, vecs[v].use_tab,
                vecs[v].exp_addr, -1);
    end

    // Foreign ID: one-cycle AR that must be ignored
    ARID = 8'h3C; ARADDR = 11'h080; ARLEN = 8'd2; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("foreign_req", 64'(axi_rd_req), 64'd0);
      chk("foreign_rvalid", 64'(RVALID), 64'd0);
      chk("foreign_doing", 64'(axi_rd_doing), 64'd0);
      chk("foreign_arready", 64'(ARREADY), 64'd1);
      @(negedge clk);
    end

    // Reset during beat 2 of 4, then a clean single-beat burst
    run_burst(11'h300, 3, 2, 2'b01, -1, -1, 0, 0, 1'b0, '0, 1);
    run_burst(vecs[0].addr, vecs[0].len, vecs[0].size, vecs[0].burst, vecs[0].err_beat,
              vecs[0].stall_beat, vecs[0].stall_n, vecs[0].lat, vecs[0].use_tab,
              vecs[0].exp_addr, -1);

    // Randomized bursts against the behavioural model
    for (int r = 0; r < 40; r++) begin
      size  = int'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 3));
      pick  = int'($urandom_range(0, 5));
      case (pick)
        0: len = 0;
        1: len = 1;
        2: len = 3;
        3: len = 7;
        4: len = 15;
        default: len = int'($urandom_range(0, 15));
      endcase
      addr = 11'($urandom) & ~11'((1 << size) - 1);
      errb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      run_burst(addr, len, size, burst, errb, -2, 0, int'($urandom_range(0, 2)),
                1'b0, '0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
